// File: rtl/mux_sync_tx_pkg.sv
// Shared types and defaults for the mux-synchronizer transmit scheduler.
package mux_sync_tx_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_TIMEOUT    = 64;
  localparam int DEF_GAP        = 2;

  // ST_GAP is prefixed so it never collides with the GAP length parameter.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search; the pointer register lives in the parent.
module rr_arbiter
  import mux_sync_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr+1 upward (wrapping) and take the first active request.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sync_tx_sched.sv
// Write-domain scheduler sharing one mux-synchronizer channel between requesters.
module mux_sync_tx_sched
  import mux_sync_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int GAP         = DEF_GAP
) (
  input  logic                          wr_clk,
  input  logic                          wr_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_req,
  input  logic                          rd_ack_tgl,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_REQ)-1:0]    done_id,
  output logic                          timeout_err
);

  localparam int IDX_W   = idx_width(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   wr_req_q, wr_req_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_W-1:0]       done_id_q, done_id_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_prev_q, ack_prev_d;

  logic                   ack_sync;
  logic                   ack_evt;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Toggle-ack synchronizer; ack_prev follows continuously so stale toggles never linger.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rd_ack_tgl};
    ack_sync   = sync_q[SYNC_STAGES-1];
    ack_evt    = ack_sync ^ ack_prev_q;
    ack_prev_d = ack_sync;
  end

  // Next-state logic: grant in IDLE, wait for ack or timeout, then hold data through the gap.
  always_comb begin
    state_d     = state_q;
    wr_data_d   = wr_data_q;
    wr_req_d    = wr_req_q;
    req_ready_d = '0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    done_id_d   = done_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          wr_data_d   = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          req_ready_d = arb_grant;
          ptr_d       = arb_idx;
          done_id_d   = arb_idx;
          wr_req_d    = 1'b1;
          cnt_d       = '0;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_evt) begin
          wr_req_d = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wr_req_d  = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state and outputs registered; synchronous active-low reset.
  always_ff @(posedge wr_clk) begin
    if (!wr_reset) begin
      state_q     <= ST_IDLE;
      wr_data_q   <= '0;
      wr_req_q    <= 1'b0;
      req_ready_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_id_q   <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      sync_q      <= '0;
      ack_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_data_q   <= wr_data_d;
      wr_req_q    <= wr_req_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      done_id_q   <= done_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      ack_prev_q  <= ack_prev_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign wr_data     = wr_data_q;
  assign wr_req      = wr_req_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
